vna_iq_demod: RTL
=================

Name: vna_iq_demod

Overview:
- Upstream stage of the SPI readout path in the VNA DSP core.
- Captures paired 12-bit ADC samples from channels A and B.
- Mixes each channel with a digital fs/4 local oscillator and accumulates over a fixed window to produce four I/Q sums.
- Holds the results for the SPI bridge to read and raises meas_done when a measurement completes.

Parameters:
- LOG2_N, 10: accumulation window of N = 2^LOG2_N samples; must be >= 2 and a multiple of 4 samples.
- SETTLE, 16: sample strobes discarded after start, before accumulation begins.
- ACC_W, 12+LOG2_N: signed width of each accumulator and result.
- ADC_OFFSET_BIN, 1: 1 = ADC codes are offset binary (MSB is inverted to form two's complement); 0 = codes are already two's complement.

Ports:
- sys_clk  in  1  system clock; the only clock in this block.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin a measurement.
- adc_conv_clk  in  1  ADC conversion clock; treated as asynchronous data and sampled in sys_clk.
- adc_a  in  12  channel A sample.
- adc_b  in  12  channel B sample.
- busy  out  1  high from an accepted start until results are latched.
- meas_done  out  1  high from completion until the next accepted start.
- rd_sel  in  2  result select: 0=I_A, 1=Q_A, 2=I_B, 3=Q_B.
- rd_data  out  ACC_W  selected result, registered, one-cycle latency.

Behaviour:
- Reset: every output and all internal state go to 0; FSM goes to IDLE; the synchronizer is cleared. Reset mid-measurement aborts it, discards partial sums and clears the held results.
- Strobe generation:
  - adc_conv_clk passes through a 2-FF synchronizer, then a rising-edge detect.
  - On the detect cycle, sample_stb is high for one cycle and adc_a/adc_b are registered as xa/xb (MSB-inverted when ADC_OFFSET_BIN=1).
  - sys_clk must run at >= 4x adc_conv_clk.
- FSM states: IDLE, SETTLE, ACCUM, LATCH.
  - IDLE: on start, clear the sample counter and all four accumulators, set busy=1, clear meas_done, go to SETTLE. If SETTLE=0, go straight to ACCUM.
  - SETTLE: count sample_stb. After SETTLE strobes, go to ACCUM with cnt=0.
  - ACCUM: on the cycle after each sample_stb, phase p=cnt[1:0] selects the update for both channels:
    - p0: I += x
    - p1: Q += x
    - p2: I -= x
    - p3: Q -= x
    - cnt then increments. After the N-th update, go to LATCH.
  - LATCH: copy the accumulators into the result registers, set meas_done=1 and busy=0, return to IDLE. meas_done is high exactly 3 sys_clk cycles after the final sample_stb.
- start while busy is ignored. start in the same cycle as rst: reset wins.
- Arithmetic:
  - Sign-extend x to ACC_W; wrap-around arithmetic, no saturation.
  - ACC_W covers the worst case N/2 * 2048 magnitude, so overflow cannot occur at the default width.
- Results:
  - Held unchanged until the next LATCH; reads during a measurement return the previous results.
  - rd_data = result[rd_sel] registered; it updates one cycle after rd_sel changes.
  - If rd_sel is held during LATCH, rd_data shows the new value one cycle later.
- sample_stb arriving in IDLE or LATCH is ignored.

Decomposition:
- Shared package vna_dsp_pkg holds:
  - FSM state encoding
  - rd_sel index constants (RES_IA, RES_QA, RES_IB, RES_QB)
  - ADC_W=12
  - a function that converts an offset-binary code to signed
- One natural sub-module: vna_adc_capture, containing the synchronizer, edge detect, sample registers and format conversion, with outputs sample_stb, xa, xb.
- Accumulators and FSM stay in the top module.

Test Plan (LOG2_N=4, SETTLE=4, ACC_W=16, ADC_OFFSET_BIN=1, adc_conv_clk = sys_clk/8):
- DC test: adc_a=adc_b=0x800 constant; pulse start -> all four results 0, meas_done rises, busy falls.
- Channel A cosine: repeating adc_a sequence 0xBE8, 0x800, 0x418, 0x800 (±1000), aligned to the first accumulated sample -> I_A=8000, Q_A=0. Channel B held at 0x800 -> I_B=Q_B=0.
- Channel B sine: repeating adc_b sequence 0x800, 0xBE8, 0x800, 0x418 -> Q_B=8000, I_B=0. Read all four via rd_sel 0..3 and check rd_data one cycle after each select.
- Full-scale: adc_a 0xFFF on p0 and 0x000 on p2, 0x800 elsewhere -> I_A=16380 with no wrap.
- Handshake: second start while busy -> ignored, with exactly SETTLE+N strobes consumed. meas_done rises exactly 3 cycles after the 20th sample_stb and stays high until the next start.
- Reset mid-ACCUM (after 7 samples) -> busy=0, meas_done=0, rd_data=0 for every rd_sel. A new start afterwards yields correct results.

Source files
------------

// File: rtl/vna_dsp_pkg.sv
// -----------------------------------------------------------------------------
// vna_dsp_pkg
// Shared definitions for the VNA DSP core readout path.
//   - ADC_W            : width of one ADC sample
//   - meas_state_e     : measurement FSM state encoding
//   - RES_IA..RES_QB   : rd_sel indices of the four I/Q results
//   - offset_bin_to_signed : offset-binary ADC code -> two's complement
// -----------------------------------------------------------------------------
package vna_dsp_pkg;

    localparam int ADC_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_LATCH  = 2'd3
    } meas_state_e;

    localparam logic [1:0] RES_IA = 2'd0;
    localparam logic [1:0] RES_QA = 2'd1;
    localparam logic [1:0] RES_IB = 2'd2;
    localparam logic [1:0] RES_QB = 2'd3;

    // Offset binary puts mid-scale at 0x800; flipping the MSB re-centres it on 0.
    function automatic logic signed [ADC_W-1:0] offset_bin_to_signed(
        input logic [ADC_W-1:0] code
    );
        return {~code[ADC_W-1], code[ADC_W-2:0]};
    endfunction

endpackage

// File: rtl/vna_adc_capture.sv
// -----------------------------------------------------------------------------
// vna_adc_capture
// Brings the ADC conversion clock into the sys_clk domain and captures one
// sample pair per conversion.
// Ports:
//   sys_clk      in   system clock
//   rst          in   synchronous active-high reset
//   adc_conv_clk in   ADC conversion clock, treated as asynchronous data
//   adc_a/adc_b  in   raw 12-bit ADC codes
//   sample_stb   out  one-cycle pulse per conversion, aligned with xa/xb
//   xa/xb        out  captured samples in two's complement
// -----------------------------------------------------------------------------
module vna_adc_capture
    import vna_dsp_pkg::*;
#(
    parameter int ADC_OFFSET_BIN = 1
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    adc_conv_clk,
    input  logic [ADC_W-1:0]        adc_a,
    input  logic [ADC_W-1:0]        adc_b,
    output logic                    sample_stb,
    output logic signed [ADC_W-1:0] xa,
    output logic signed [ADC_W-1:0] xb
);

    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic                    prev_q, prev_d;
    logic                    stb_q, stb_d;
    logic signed [ADC_W-1:0] xa_q, xa_d;
    logic signed [ADC_W-1:0] xb_q, xb_d;
    logic                    conv_rise;

    function automatic logic signed [ADC_W-1:0] to_signed(input logic [ADC_W-1:0] code);
        if (ADC_OFFSET_BIN != 0) begin
            return offset_bin_to_signed(code);
        end
        return signed'(code);
    endfunction

    // sync1/sync2 form the synchronizer; prev holds the last synchronized
    // level so a rising edge is seen exactly once. The ADC data is stable
    // around its conversion edge, so it is taken directly on the detect cycle.
    always_comb begin
        sync1_d   = adc_conv_clk;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        conv_rise = sync2_q & ~prev_q;
        stb_d     = conv_rise;
        xa_d      = xa_q;
        xb_d      = xb_q;
        if (conv_rise) begin
            xa_d = to_signed(adc_a);
            xb_d = to_signed(adc_b);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            stb_q   <= 1'b0;
            xa_q    <= '0;
            xb_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            stb_q   <= stb_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
        end
    end

    assign sample_stb = stb_q;
    assign xa         = xa_q;
    assign xb         = xb_q;

endmodule

// File: rtl/vna_iq_demod.sv
// -----------------------------------------------------------------------------
// vna_iq_demod
// Two-channel fs/4 I/Q demodulator. Mixes each ADC channel with a digital
// LO whose cos/sin take the values {1,0,-1,0}/{0,1,0,-1}, sums over N=2^LOG2_N
// samples after SETTLE discarded samples, and holds the four sums for readout.
// Ports:
//   sys_clk      in   system clock
//   rst          in   synchronous active-high reset
//   start        in   one-cycle measurement request (ignored while busy)
//   adc_conv_clk in   ADC conversion clock (asynchronous)
//   adc_a/adc_b  in   12-bit ADC samples
//   busy         out  measurement in progress
//   meas_done    out  results valid; held until the next accepted start
//   rd_sel       in   result select: 0=I_A 1=Q_A 2=I_B 3=Q_B
//   rd_data      out  selected result, registered (one-cycle latency)
// -----------------------------------------------------------------------------
module vna_iq_demod
    import vna_dsp_pkg::*;
#(
    parameter int LOG2_N         = 10,
    parameter int SETTLE         = 16,
    parameter int ACC_W          = 12 + LOG2_N,
    parameter int ADC_OFFSET_BIN = 1
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             adc_conv_clk,
    input  logic [ADC_W-1:0] adc_a,
    input  logic [ADC_W-1:0] adc_b,
    output logic             busy,
    output logic             meas_done,
    input  logic [1:0]       rd_sel,
    output logic [ACC_W-1:0] rd_data
);

    localparam int N        = 1 << LOG2_N;
    localparam int SET_BITS = $clog2(SETTLE + 1);
    localparam int CNT_W    = (SET_BITS > LOG2_N + 1) ? SET_BITS : LOG2_N + 1;
    localparam logic [CNT_W-1:0] N_CNT       = CNT_W'(N);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    logic                    sample_stb;
    logic signed [ADC_W-1:0] xa;
    logic signed [ADC_W-1:0] xb;
    logic signed [ACC_W-1:0] xa_ext;
    logic signed [ACC_W-1:0] xb_ext;

    meas_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] acc_d [4];
    logic signed [ACC_W-1:0] res_q [4];
    logic signed [ACC_W-1:0] res_d [4];
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ACC_W-1:0]        rd_data_q, rd_data_d;

    vna_adc_capture #(
        .ADC_OFFSET_BIN(ADC_OFFSET_BIN)
    ) u_capture (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .adc_conv_clk(adc_conv_clk),
        .adc_a       (adc_a),
        .adc_b       (adc_b),
        .sample_stb  (sample_stb),
        .xa          (xa),
        .xb          (xb)
    );

    assign xa_ext = {{(ACC_W - ADC_W){xa[ADC_W-1]}}, xa};
    assign xb_ext = {{(ACC_W - ADC_W){xb[ADC_W-1]}}, xb};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        res_d     = res_q;
        busy_d    = busy_q;
        done_d    = done_q;
        rd_data_d = res_q[rd_sel];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = '0;
                    end
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (sample_stb) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_ACCUM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // The LO phase is the low two bits of the sample count. The exit
            // test runs one cycle after the N-th update, which puts meas_done
            // three cycles after the final strobe.
            ST_ACCUM: begin
                if (cnt_q == N_CNT) begin
                    state_d = ST_LATCH;
                end else if (sample_stb) begin
                    case (cnt_q[1:0])
                        2'd0: begin
                            acc_d[RES_IA] = acc_q[RES_IA] + xa_ext;
                            acc_d[RES_IB] = acc_q[RES_IB] + xb_ext;
                        end
                        2'd1: begin
                            acc_d[RES_QA] = acc_q[RES_QA] + xa_ext;
                            acc_d[RES_QB] = acc_q[RES_QB] + xb_ext;
                        end
                        2'd2: begin
                            acc_d[RES_IA] = acc_q[RES_IA] - xa_ext;
                            acc_d[RES_IB] = acc_q[RES_IB] - xb_ext;
                        end
                        default: begin
                            acc_d[RES_QA] = acc_q[RES_QA] - xa_ext;
                            acc_d[RES_QB] = acc_q[RES_QB] - xb_ext;
                        end
                    endcase
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_LATCH: begin
                res_d   = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign meas_done = done_q;
    assign rd_data   = rd_data_q;

endmodule
